pulse_train_tx: RTL and testbench
=================================

Name: pulse_train_tx

Overview:
Generates a programmable train of N low-going pulses on a single line, for the team's falling-edge counter blocks to count. Each pulse produces exactly one 1->0 transition. The block is loaded through a start/busy/done handshake. It sits on the stimulus side of the edge-counting path and drives that path's signal input directly.

Parameters:
LOW_CYCLES, 2, clock cycles signal_out is held low per pulse (>=1)
HIGH_CYCLES, 2, clock cycles signal_out is held high after each low phase (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous reset, active-high
start  input  1  request a train; sampled only while idle
count_in  input  8  number of pulses to send (0..255), sampled with accepted start
abort  input  1  terminate the current train; line returns high
signal_out  output  1  pulse line, idles high
busy  output  1  high while a train is in progress
done  output  1  one-cycle strobe on normal completion
pulses_sent  output  8  falling edges emitted in current/last train

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset). All outputs are registered.
- Reset values: signal_out=1, busy=0, done=0, pulses_sent=0, state IDLE, phase counter 0.
- Reset mid-train wins over everything. On the next edge the line is high and all outputs take their reset values; no done is issued.
- States: IDLE, LOW, HIGH. A phase counter sized for max(LOW_CYCLES, HIGH_CYCLES) runs in each state.
- IDLE:
  - signal_out=1, busy=0.
  - start=1 and count_in!=0 (abort=0): latch count_in as target, clear pulses_sent then increment it to 1, go to LOW. From the next cycle signal_out=0 and busy=1.
  - start=1 and count_in==0: stay in IDLE, pulses_sent=0, done=1 for exactly the next cycle, no edge emitted.
  - start and abort together in IDLE: abort wins, start ignored.
- LOW: signal_out=0 for exactly LOW_CYCLES cycles, then go to HIGH.
- HIGH: signal_out=1 for exactly HIGH_CYCLES cycles. Then:
  - pulses_sent==target: go to IDLE with busy=0, and done=1 for that one cycle.
  - otherwise: go to LOW and increment pulses_sent on the same edge that signal_out falls.
- pulses_sent always equals the number of 1->0 transitions emitted since the accepted start, and saturates at 255 by construction.
- Timing for an N-pulse train:
  - busy high for exactly N*(LOW_CYCLES+HIGH_CYCLES) cycles.
  - First falling edge is visible in the cycle after start is sampled.
  - done coincides with the first cycle of busy=0.
- start while busy is ignored; count_in is not re-sampled.
- abort while busy:
  - Next cycle: signal_out=1, busy=0, state IDLE, done stays 0.
  - pulses_sent holds its value; a pulse aborted during LOW is counted, because its falling edge was already emitted.
- Back-to-back trains: start asserted in the same cycle done=1 is accepted (state is IDLE). The new first falling edge follows one cycle later, so the line is high for at least HIGH_CYCLES+1 cycles between trains.
- signal_out must be glitch-free: it is driven only from a flop.

Test Plan:
- LOW/HIGH=2, start with count_in=3 -> exactly 3 falling edges at cycles 1, 5, 9; busy high for 12 cycles; done=1 at cycle 13 only; pulses_sent=3.
- start with count_in=0 -> signal_out stays 1, busy stays 0, done=1 for one cycle, pulses_sent=0.
- count_in=255 -> 255 falling edges, busy 1020 cycles, pulses_sent=255. Loopback into the edge-counter block reads 255.
- count_in=5, abort raised in the 2nd LOW phase -> line high on the next cycle, busy=0, pulses_sent=2, done never asserted. A following start with count_in=1 sends 1 pulse.
- count_in=4, start re-pulsed with count_in=9 mid-train -> ignored; exactly 4 edges sent, pulses_sent=4.
- reset=1 during the 3rd LOW of a 6-pulse train -> next cycle signal_out=1, busy=0, done=0, pulses_sent=0. A start with count_in=2 after release sends 2 edges.

Source files
------------

// File: rtl/pulse_train_tx_if.sv
// pulse_train_tx handshake and line bundle.
// Master drives requests, slave returns the line and status.
interface pulse_train_tx_if;
  logic       start;
  logic [7:0] count_in;
  logic       abort;
  logic       signal_out;
  logic       busy;
  logic       done;
  logic [7:0] pulses_sent;

  modport master (
    output start, count_in, abort,
    input  signal_out, busy, done, pulses_sent
  );

  modport slave (
    input  start, count_in, abort,
    output signal_out, busy, done, pulses_sent
  );
endinterface

// File: rtl/pulse_train_tx.sv
// Emits a train of N low-going pulses, one falling edge each.
// Loaded via start/busy/done; all outputs come straight from flops.
module pulse_train_tx #(
  parameter int LOW_CYCLES  = 2,
  parameter int HIGH_CYCLES = 2
) (
  input logic             clk,
  input logic             reset,
  pulse_train_tx_if.slave bus
);

  localparam int MAXC = (LOW_CYCLES > HIGH_CYCLES) ?
                        LOW_CYCLES : HIGH_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      tgt_q, tgt_d;
  logic [7:0]      sent_q, sent_d;
  logic            sig_q, sig_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            go;
  logic            low_end;
  logic            high_end;
  logic            last;

  assign go       = bus.start && !bus.abort;
  assign low_end  = cnt_q == CW'(LOW_CYCLES - 1);
  assign high_end = cnt_q == CW'(HIGH_CYCLES - 1);
  assign last     = sent_q == tgt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tgt_q   <= '0;
      sent_q  <= '0;
      sig_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      sent_q  <= sent_d;
      sig_q   <= sig_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (go && bus.count_in != 8'd0)
          state_d = LOW;
      end
      LOW: begin
        if (bus.abort)
          state_d = IDLE;
        else if (low_end)
          state_d = HIGH;
      end
      HIGH: begin
        if (bus.abort)
          state_d = IDLE;
        else if (high_end)
          state_d = last ? IDLE : LOW;
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level and busy follow the next state so they toggle on the
  // same edge as the transition.
  always_comb begin
    sig_d  = state_d != LOW;
    busy_d = state_d != IDLE;
    cnt_d  = '0;
    if (state_d != IDLE && state_d == state_q)
      cnt_d = cnt_q + 1'b1;
    tgt_d  = tgt_q;
    sent_d = sent_q;
    done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          tgt_d  = bus.count_in;
          sent_d = (bus.count_in != 8'd0) ? 8'd1 : 8'd0;
          done_d = bus.count_in == 8'd0;
        end
      end
      HIGH: begin
        if (!bus.abort && high_end) begin
          if (last)
            done_d = 1'b1;
          else
            sent_d = sent_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  assign bus.signal_out  = sig_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.pulses_sent = sent_q;

endmodule

// File: tb/tb_pulse_train_tx.sv
// Directed bench for pulse_train_tx with a per-train scoreboard.
// Monitor tallies edges/busy/done; trains are checked on completion.
module tb_pulse_train_tx;

  logic clk = 1'b0;
  logic reset;

  pulse_train_tx_if bus ();

  pulse_train_tx #(
    .LOW_CYCLES (2),
    .HIGH_CYCLES(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         edges;
    int         busy;
    int         dones;
    int         done_at;
    logic [7:0] ps;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  int   edges_tot = 0;
  int   busy_tot  = 0;
  int   done_tot  = 0;
  logic prev_sig  = 1'b1;

  always @(posedge clk) begin
    #2;
    if (prev_sig === 1'b1 && bus.signal_out === 1'b0)
      edges_tot++;
    if (bus.busy === 1'b1)
      busy_tot++;
    if (bus.done === 1'b1)
      done_tot++;
    prev_sig = bus.signal_out;
  end

  task automatic check(input string tag,
                       input int obs,
                       input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ev_kind: 0 none, 1 restart start with 9, 2 abort, 3 reset
  task automatic run(input int n,
                     input int ev_at,
                     input int ev_kind,
                     input int e_edges,
                     input int e_busy,
                     input int e_done_at,
                     input int e_ps);
    exp_t e;
    int   s_edges, s_busy, s_done;
    int   done_at;
    e.edges   = e_edges;
    e.busy    = e_busy;
    e.dones   = (e_done_at >= 0) ? 1 : 0;
    e.done_at = e_done_at;
    e.ps      = 8'(e_ps);
    exp_q.push_back(e);
    done_at = -1;
    @(negedge clk);
    s_edges      = edges_tot;
    s_busy       = busy_tot;
    s_done       = done_tot;
    bus.start    = 1'b1;
    bus.count_in = 8'(n);
    for (int k = 1; k <= n * 4 + 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) begin
        bus.start    = 1'b0;
        bus.count_in = 8'd0;
        if (n > 0) begin
          check("first_edge", int'(bus.signal_out), 0);
          check("first_busy", int'(bus.busy), 1);
        end
      end
      if (bus.done === 1'b1 && done_at < 0)
        done_at = k;
      if (ev_kind != 0 && k == ev_at + 1) begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        reset     = 1'b0;
        if (ev_kind >= 2) begin
          check("ev_line", int'(bus.signal_out), 1);
          check("ev_busy", int'(bus.busy), 0);
          check("ev_done", int'(bus.done), 0);
        end
      end
      if (ev_kind != 0 && k == ev_at) begin
        unique case (ev_kind)
          1: begin
            bus.start    = 1'b1;
            bus.count_in = 8'd9;
          end
          2: bus.abort = 1'b1;
          default: reset = 1'b1;
        endcase
      end
    end
    e = exp_q.pop_front();
    check("edges", edges_tot - s_edges, e.edges);
    check("busy_cycles", busy_tot - s_busy, e.busy);
    check("done_count", done_tot - s_done, e.dones);
    check("done_cycle", done_at, e.done_at);
    check("pulses_sent", int'(bus.pulses_sent), int'(e.ps));
  endtask

  initial begin
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    bus.count_in = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_line", int'(bus.signal_out), 1);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_ps", int'(bus.pulses_sent), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    run(3, 0, 0, 3, 12, 13, 3);
    run(0, 0, 0, 0, 0, 1, 0);
    run(255, 0, 0, 255, 1020, 1021, 255);
    run(5, 5, 2, 2, 5, -1, 2);
    run(1, 0, 0, 1, 4, 5, 1);
    run(4, 6, 1, 4, 16, 17, 4);
    run(6, 9, 3, 3, 9, -1, 0);
    run(2, 0, 0, 2, 8, 9, 2);

    // start and abort together while idle: abort wins
    @(negedge clk);
    bus.start    = 1'b1;
    bus.abort    = 1'b1;
    bus.count_in = 8'd3;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("sa_line", int'(bus.signal_out), 1);
    check("sa_busy", int'(bus.busy), 0);
    check("sa_done", int'(bus.done), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
